// File: rtl/result_frame_rx_if.sv
// result_frame_rx_if: serial line in, decoded result words and status pulses out.
// master drives the UART line and observes results; slave is the receiver.
interface result_frame_rx_if;
    logic        serial;
    logic        frame_valid;
    logic        frame_err;
    logic [15:0] obs_alert;
    logic [15:0] max_dist_angle;
    logic [15:0] min_dist_angle;
    modport master (output serial, input frame_valid, frame_err, obs_alert, max_dist_angle, min_dist_angle);
    modport slave  (input serial, output frame_valid, frame_err, obs_alert, max_dist_angle, min_dist_angle);
endinterface

// File: rtl/result_frame_rx.sv
// result_frame_rx: 8N1 UART receiver and AA 55 framed result decoder with XOR checksum.
// Optional inter-byte timeout is enabled by defining RESULT_RX_TIMEOUT_EN.
module result_frame_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int TIMEOUT_BITS = 20
) (
    input logic              clk,
    input logic              reset,
    result_frame_rx_if.slave bus
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);

    if (CLKS_PER_BIT < 4 || TIMEOUT_BITS < 1) begin : g_bad_param
        $error("result_frame_rx: CLKS_PER_BIT must be >= 4 and TIMEOUT_BITS >= 1");
    end

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_t;
    typedef enum logic [1:0] {F_HUNT, F_HDR2, F_PAYLOAD, F_CHK} frm_t;

    logic [1:0]    r_sync;
    logic          r_prev;
    bit_t          r_bst;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    frm_t          r_fst;
    logic [2:0]    r_idx;
    logic [47:0]   r_shadow;
    logic [7:0]    r_xor;
    logic          r_valid;
    logic          r_err;
    logic [15:0]   r_obs;
    logic [15:0]   r_max;
    logic [15:0]   r_min;
    logic          w_rx;
    logic          w_start;
    logic          w_mid;
    logic          w_full;
    logic          w_byte_ok;
    logic          w_byte_bad;
    logic          w_timeout;

    assign w_rx       = r_sync[1];
    assign w_start    = r_bst == B_IDLE && r_prev && !w_rx;
    assign w_mid      = r_cnt == CW'(HALF);
    assign w_full     = r_cnt == CW'(CLKS_PER_BIT);
    assign w_byte_ok  = r_bst == B_STOP && w_full && w_rx;
    assign w_byte_bad = r_bst == B_STOP && w_full && !w_rx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], bus.serial};
            r_prev <= w_rx;
        end
    end

    // r_cnt equals the number of cycles since the last edge or sample point
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bst   <= B_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            case (r_bst)
                B_IDLE: begin
                    r_cnt <= CW'(1);
                    if (w_start) r_bst <= B_START;
                end
                B_START: if (w_mid) begin
                    r_cnt <= CW'(1);
                    r_bit <= '0;
                    r_bst <= w_rx ? B_IDLE : B_DATA;
                end
                B_DATA: if (w_full) begin
                    r_cnt   <= CW'(1);
                    r_shift <= {w_rx, r_shift[7:1]};
                    r_bit   <= r_bit + 1'b1;
                    if (r_bit == 3'd7) r_bst <= B_STOP;
                end
                B_STOP: if (w_full) r_bst <= B_IDLE;
            endcase
        end
    end

`ifdef RESULT_RX_TIMEOUT_EN
    localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW     = $clog2(TO_CYC + 1);
    logic [TW-1:0] r_to;
    assign w_timeout = r_fst != F_HUNT && r_bst == B_IDLE && !w_start && r_to == TW'(TO_CYC - 1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_to <= '0;
        else r_to <= (r_fst == F_HUNT || w_start) ? '0 : r_bst == B_IDLE ? r_to + 1'b1 : r_to;
    end
`else
    assign w_timeout = 1'b0;
`endif

    // payload bytes shift in from the top so byte 2 ends up in r_shadow[7:0]
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fst    <= F_HUNT;
            r_idx    <= '0;
            r_shadow <= '0;
            r_xor    <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_obs    <= '0;
            r_max    <= '0;
            r_min    <= '0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_byte_bad || w_timeout) begin
                r_err <= 1'b1;
                r_fst <= F_HUNT;
            end else if (w_byte_ok) begin
                case (r_fst)
                    F_HUNT: if (r_shift == 8'hAA) r_fst <= F_HDR2;
                    F_HDR2: begin
                        r_fst <= r_shift == 8'h55 ? F_PAYLOAD : r_shift == 8'hAA ? F_HDR2 : F_HUNT;
                        r_idx <= '0;
                        r_xor <= '0;
                    end
                    F_PAYLOAD: begin
                        r_shadow <= {r_shift, r_shadow[47:8]};
                        r_xor    <= r_xor ^ r_shift;
                        r_idx    <= r_idx + 1'b1;
                        if (r_idx == 3'd5) r_fst <= F_CHK;
                    end
                    F_CHK: begin
                        r_fst <= F_HUNT;
                        if (r_shift == r_xor) begin
                            r_valid <= 1'b1;
                            r_obs   <= r_shadow[15:0];
                            r_max   <= r_shadow[31:16];
                            r_min   <= r_shadow[47:32];
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.frame_valid    = r_valid;
    assign bus.frame_err      = r_err;
    assign bus.obs_alert      = r_obs;
    assign bus.max_dist_angle = r_max;
    assign bus.min_dist_angle = r_min;
endmodule
